// File: rtl/gol_pkg.sv
`default_nettype none
// gol_pkg -- shared grid constants, op/state encodings and glider stamp helpers. Rev 1.0
package gol_pkg;

   localparam int GRID_N  = 800;
   localparam int GRID_M  = 600;
   localparam int COORD_W = 12;

   typedef enum logic [1:0] {
      OP_TOGGLE = 2'd0,
      OP_SET    = 2'd1,
      OP_CLEAR  = 2'd2,
      OP_STAMP  = 2'd3
   } op_e;

   // Bit index is dy*3+dx within the 3x3 block.
   localparam logic [8:0] GLIDER = 9'b1_1110_0010;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      STAMP = 3'd4,
      DONE  = 3'd5
   } state_e;

   function automatic logic [3:0] stamp_offset(input logic [3:0] idx);
      logic [3:0] dydx;
      case (idx)
         4'd0:    dydx = {2'd0, 2'd0};
         4'd1:    dydx = {2'd0, 2'd1};
         4'd2:    dydx = {2'd0, 2'd2};
         4'd3:    dydx = {2'd1, 2'd0};
         4'd4:    dydx = {2'd1, 2'd1};
         4'd5:    dydx = {2'd1, 2'd2};
         4'd6:    dydx = {2'd2, 2'd0};
         4'd7:    dydx = {2'd2, 2'd1};
         4'd8:    dydx = {2'd2, 2'd2};
         default: dydx = 4'd0;
      endcase
      return dydx;
   endfunction

   function automatic logic glider_live(input logic [3:0] idx);
      return (idx < 4'd9) ? GLIDER[idx] : 1'b0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/torus_addr.sv
`default_nettype none
// torus_addr -- wraps (h+dx, v+dy) onto the torus and forms the linear cell address. Rev 1.0
module torus_addr
   import gol_pkg::*;
#(
   parameter int P_PARAM_N = GRID_N,
   parameter int P_PARAM_M = GRID_M,
   parameter int ADDR_W    = 24
) (
   input  logic [COORD_W-1:0] h,
   input  logic [COORD_W-1:0] v,
   input  logic [1:0]         dx,
   input  logic [1:0]         dy,
   output logic [ADDR_W-1:0]  addr
);

   localparam int SUM_W = COORD_W + 1;
   localparam logic [SUM_W-1:0] N_C = SUM_W'(P_PARAM_N);
   localparam logic [SUM_W-1:0] M_C = SUM_W'(P_PARAM_M);

   logic [SUM_W-1:0] h_sum;
   logic [SUM_W-1:0] v_sum;
   logic [SUM_W-1:0] h_wrap;
   logic [SUM_W-1:0] v_wrap;

   // Offsets are at most 2, so a single subtraction covers the wrap.
   always_comb begin
      h_sum  = {1'b0, h} + {{(SUM_W-2){1'b0}}, dx};
      v_sum  = {1'b0, v} + {{(SUM_W-2){1'b0}}, dy};
      h_wrap = (h_sum >= N_C) ? h_sum - N_C : h_sum;
      v_wrap = (v_sum >= M_C) ? v_sum - M_C : v_sum;
      addr   = ADDR_W'(v_wrap) * ADDR_W'(P_PARAM_N) + ADDR_W'(h_wrap);
   end

endmodule
`default_nettype wire

// File: rtl/cell_editor.sv
`default_nettype none
// cell_editor -- applies toggle/set/clear/glider-stamp edits at the cursor to the cell RAM. Rev 1.0
module cell_editor
   import gol_pkg::*;
#(
   parameter int P_PARAM_N = GRID_N,
   parameter int P_PARAM_M = GRID_M,
   parameter int ADDR_W    = 24,
   parameter int RD_LAT    = 2
) (
   input  logic                clk_vga,
   input  logic                reset_btn,
   input  logic                en,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic [COORD_W-1:0]  cur_h,
   input  logic [COORD_W-1:0]  cur_v,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic                ram_rden,
   output logic                ram_wden,
   output logic                ram_wdata,
   input  logic                ram_rdata,
   output logic                done,
   output logic                err
);

   localparam logic [COORD_W-1:0] N_COORD  = COORD_W'(P_PARAM_N);
   localparam logic [COORD_W-1:0] M_COORD  = COORD_W'(P_PARAM_M);
   localparam logic [1:0]         LAT_LAST = 2'(RD_LAT - 1);

   state_e              state_q, state_d;
   op_e                 op_q, op_d;
   logic [COORD_W-1:0]  h_q, h_d, v_q, v_d;
   logic [3:0]          idx_q, idx_d;
   logic [1:0]          lat_q, lat_d;
   logic                idle_q, idle_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                rden_q, rden_d, wden_q, wden_d, wdata_q, wdata_d;
   logic                done_q, done_d, err_q, err_d;

   logic                accept;
   logic                in_range;
   logic [3:0]          nxt_idx;
   logic [3:0]          offs;
   logic [COORD_W-1:0]  ta_h, ta_v;
   logic [ADDR_W-1:0]   ta_addr;

   // idle_q stays low while reset is held, keeping cmd_ready low too.
   assign cmd_ready = idle_q && en;
   assign accept    = cmd_valid && cmd_ready;
   assign in_range  = (cur_h < N_COORD) && (cur_v < M_COORD);
   assign nxt_idx   = accept ? 4'd0 : idx_q + 4'd1;
   assign offs      = stamp_offset(nxt_idx);
   assign ta_h      = accept ? cur_h : h_q;
   assign ta_v      = accept ? cur_v : v_q;

   torus_addr #(
      .P_PARAM_N (P_PARAM_N),
      .P_PARAM_M (P_PARAM_M),
      .ADDR_W    (ADDR_W)
   ) u_torus_addr (
      .h    (ta_h),
      .v    (ta_v),
      .dx   (offs[1:0]),
      .dy   (offs[3:2]),
      .addr (ta_addr)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      h_d     = h_q;
      v_d     = v_q;
      idx_d   = idx_q;
      lat_d   = lat_q;
      addr_d  = addr_q;
      rden_d  = 1'b0;
      wden_d  = 1'b0;
      wdata_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d  = op_e'(cmd_op);
               h_d   = cur_h;
               v_d   = cur_v;
               idx_d = 4'd0;
               if (!in_range) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  addr_d = ta_addr;
                  case (op_e'(cmd_op))
                     OP_TOGGLE: begin
                        state_d = READ;
                        rden_d  = 1'b1;
                     end
                     OP_SET: begin
                        state_d = WRITE;
                        wden_d  = 1'b1;
                        wdata_d = 1'b1;
                     end
                     OP_CLEAR: begin
                        state_d = WRITE;
                        wden_d  = 1'b1;
                     end
                     default: begin
                        state_d = STAMP;
                        wden_d  = 1'b1;
                        wdata_d = glider_live(4'd0);
                     end
                  endcase
               end
            end
         end
         READ: begin
            state_d = WAIT;
            lat_d   = 2'd0;
         end
         WAIT: begin
            // Leaves on the cycle ram_rdata carries the requested cell.
            if (lat_q == LAT_LAST) begin
               state_d = WRITE;
               wden_d  = 1'b1;
               wdata_d = ~ram_rdata;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         WRITE: begin
            state_d = DONE;
            done_d  = 1'b1;
         end
         STAMP: begin
            if (idx_q == 4'd8 || op_q != OP_STAMP) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               idx_d   = nxt_idx;
               addr_d  = ta_addr;
               wden_d  = 1'b1;
               wdata_d = glider_live(nxt_idx);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      idle_d = (state_d == IDLE);
   end

   always_ff @(posedge clk_vga or posedge reset_btn) begin
      if (reset_btn) begin
         state_q <= IDLE;
         op_q    <= OP_TOGGLE;
         h_q     <= '0;
         v_q     <= '0;
         idx_q   <= 4'd0;
         lat_q   <= 2'd0;
         idle_q  <= 1'b0;
         addr_q  <= '0;
         rden_q  <= 1'b0;
         wden_q  <= 1'b0;
         wdata_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         h_q     <= h_d;
         v_q     <= v_d;
         idx_q   <= idx_d;
         lat_q   <= lat_d;
         idle_q  <= idle_d;
         addr_q  <= addr_d;
         rden_q  <= rden_d;
         wden_q  <= wden_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign ram_addr  = addr_q;
   assign ram_rden  = rden_q;
   assign ram_wden  = wden_q;
   assign ram_wdata = wdata_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
`default_nettype wire
